// File: rtl/key_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_cmd_pkg
//  Purpose  : Shared constants for the key-to-flash command sequencer:
//             command opcodes, event codes, FSM state encoding and a
//             saturating counter helper.
//  Revision : 1.0  initial release
// ============================================================================
package key_cmd_pkg;

    // Flash controller opcodes
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ERASE = 2'b11;

    // Event codes stored in the event queue
    localparam logic EV_SHORT = 1'b0;
    localparam logic EV_LONG  = 1'b1;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_ER_REQ  = 3'd5,
        ST_ER_WAIT = 3'd6
    } state_t;

    // 8-bit increment that sticks at 8'hFF
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : evt_fifo
//  Purpose  : Small synchronous show-ahead FIFO. A push while full is
//             accepted when it coincides with a pop. Reports whether the
//             current push is taken and the occupancy after this edge.
//  Revision : 1.0  initial release
// ============================================================================
module evt_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_push_ok,
    output logic [$clog2(DEPTH):0]   o_level_nxt
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic             w_pop;
    logic             w_push;
    logic [c_AW:0]    w_level_nxt;

    assign o_full      = (r_count == c_FULL);
    assign o_empty     = (r_count == '0);
    assign o_dout      = r_mem[r_rd_ptr];
    assign w_pop       = i_pop & ~o_empty;
    // A full FIFO frees a slot on the same edge it is popped
    assign w_push      = i_push & (~o_full | w_pop);
    assign o_push_ok   = w_push;
    assign o_level_nxt = w_level_nxt;

    // Occupancy after this edge
    always_comb begin
        w_level_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_count + 1'b1;
            2'b01:   w_level_nxt = r_count - 1'b1;
            default: w_level_nxt = r_count;
        endcase
    end

    // Storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_level_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : key_cmd_seq
//  Purpose  : Converts debounced short/long key events into SPI flash
//             commands. Short press: WRITE next byte then READ it back and
//             compare. Long press: ERASE the test region and clear state.
//  Revision : 1.0  initial release
// ============================================================================
module key_cmd_seq
    import key_cmd_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE = 24'h000000,
    parameter int          ADDR_SPAN = 256,
    parameter int          EVQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_short,
    input  logic        key_long,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [23:0] cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        verify_err,
    output logic [7:0]  drop_cnt
);

    localparam logic [23:0] c_ADDR_LAST = ADDR_BASE + 24'(ADDR_SPAN - 1);

    logic        r_short_d;
    logic        r_long_d;
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_cmd_valid;
    logic [1:0]  r_cmd_op;
    logic [23:0] r_cmd_addr;
    logic [7:0]  r_cmd_wdata;
    logic [23:0] r_cur_addr;
    logic [7:0]  r_data_cnt;
    logic        r_verify_err;
    logic [7:0]  r_drop_cnt;
    logic        r_busy;

    logic        w_ev_short;
    logic        w_ev_long;
    logic        w_push;
    logic        w_ev_code;
    logic        w_pop;
    logic        w_hs;
    logic        w_full;
    logic        w_empty;
    logic        w_dout;
    logic        w_push_ok;
    logic [$clog2(EVQ_DEPTH):0] w_level_nxt;

    // Rising-edge detection; LONG wins when both keys fire together
    assign w_ev_short = key_short & ~r_short_d;
    assign w_ev_long  = key_long  & ~r_long_d;
    assign w_push     = w_ev_short | w_ev_long;
    assign w_ev_code  = w_ev_long ? EV_LONG : EV_SHORT;

    assign w_pop = (r_state == ST_IDLE) & ~w_empty;
    assign w_hs  = r_cmd_valid & cmd_ready;

    assign cmd_valid  = r_cmd_valid;
    assign cmd_op     = r_cmd_op;
    assign cmd_addr   = r_cmd_addr;
    assign cmd_wdata  = r_cmd_wdata;
    assign busy       = r_busy;
    assign verify_err = r_verify_err;
    assign drop_cnt   = r_drop_cnt;

    evt_fifo #(
        .WIDTH (1),
        .DEPTH (EVQ_DEPTH)
    ) u_evq (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_din       (w_ev_code),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_dout      (w_dout),
        .o_push_ok   (w_push_ok),
        .o_level_nxt (w_level_nxt)
    );

    // Delayed key copies for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_short_d <= 1'b0;
            r_long_d  <= 1'b0;
        end else begin
            r_short_d <= key_short;
            r_long_d  <= key_long;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (!w_empty)  w_state_nxt = (w_dout == EV_LONG) ? ST_ER_REQ : ST_WR_REQ;
            ST_WR_REQ:  if (w_hs)      w_state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: if (rsp_valid) w_state_nxt = ST_RD_REQ;
            ST_RD_REQ:  if (w_hs)      w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (rsp_valid) w_state_nxt = ST_IDLE;
            ST_ER_REQ:  if (w_hs)      w_state_nxt = ST_ER_WAIT;
            ST_ER_WAIT: if (rsp_valid) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and registered busy (state/occupancy after this edge)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE) | (w_level_nxt != '0);
        end
    end

    // Command outputs: raised the cycle after entering a request state,
    // held until accepted, and zero whenever no request is presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_NONE;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_NONE;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            if (!w_hs) begin
                case (r_state)
                    ST_WR_REQ: begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= OP_WRITE;
                        r_cmd_addr  <= r_cur_addr;
                        r_cmd_wdata <= r_data_cnt;
                    end
                    ST_RD_REQ: begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= OP_READ;
                        r_cmd_addr  <= r_cur_addr;
                        r_cmd_wdata <= r_data_cnt;
                    end
                    ST_ER_REQ: begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= OP_ERASE;
                        r_cmd_addr  <= ADDR_BASE;
                        r_cmd_wdata <= r_data_cnt;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Address/data progression and read-back verification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr   <= ADDR_BASE;
            r_data_cnt   <= 8'h00;
            r_verify_err <= 1'b0;
        end else if (rsp_valid) begin
            if (r_state == ST_RD_WAIT) begin
                if (rsp_rdata != r_data_cnt) r_verify_err <= 1'b1;
                r_data_cnt <= r_data_cnt + 8'd1;
                r_cur_addr <= (r_cur_addr == c_ADDR_LAST) ? ADDR_BASE : r_cur_addr + 24'd1;
            end else if (r_state == ST_ER_WAIT) begin
                r_cur_addr   <= ADDR_BASE;
                r_data_cnt   <= 8'h00;
                r_verify_err <= 1'b0;
            end
        end
    end

    // Saturating count of events lost to a full queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'h00;
        end else if (w_push && !w_push_ok) begin
            r_drop_cnt <= sat_inc8(r_drop_cnt);
        end
    end

    // Full flag is implied by push-not-accepted; kept visible for debug
    logic w_unused;
    assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_cmd_seq
//  Purpose  : Scoreboard bench for key_cmd_seq. Directed key stimulus pushes
//             expected commands; a monitor pops and compares on each
//             accepted request; a responder models the flash controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_cmd_seq;
    import key_cmd_pkg::*;

    localparam logic [23:0] c_BASE  = 24'h000000;
    localparam int          c_SPAN  = 4;
    localparam int          c_DEPTH = 4;

    typedef struct packed {
        logic [1:0]  op;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    logic        clk;
    logic        rst_n;
    logic        key_short;
    logic        key_long;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        verify_err;
    logic [7:0]  drop_cnt;

    cmd_t        exp_q[$];
    int          n_checks;
    int          n_pass;
    logic [23:0] m_addr;
    logic [7:0]  m_data;
    logic [7:0]  mem [256];
    bit          auto_rsp;
    bit          corrupt_next;
    bit          pend;
    cmd_t        pend_cmd;

    key_cmd_seq #(
        .ADDR_BASE (c_BASE),
        .ADDR_SPAN (c_SPAN),
        .EVQ_DEPTH (c_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_short  (key_short),
        .key_long   (key_long),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .verify_err (verify_err),
        .drop_cnt   (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit s, input bit l, input int hold);
        key_short = s;
        key_long  = l;
        repeat (hold) step();
        key_short = 1'b0;
        key_long  = 1'b0;
        step();
    endtask

    task automatic exp_short();
        exp_q.push_back('{OP_WRITE, m_addr, m_data});
        exp_q.push_back('{OP_READ,  m_addr, m_data});
        m_data = m_data + 8'd1;
        m_addr = (m_addr == c_BASE + 24'(c_SPAN - 1)) ? c_BASE : m_addr + 24'd1;
    endtask

    task automatic exp_long();
        exp_q.push_back('{OP_ERASE, c_BASE, 8'h00});
        m_addr = c_BASE;
        m_data = 8'h00;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!busy && exp_q.size() == 0 && !pend) break;
            step();
        end
        chk("wait_idle_in_budget", 64'(i < budget), 64'd1);
    endtask

    // Monitor: compare each accepted request against the scoreboard
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cmd_valid) begin
                    if (cmd_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_cmd: got op %0d addr 0x%0h, expected none", cmd_op, cmd_addr);
                        end else begin
                            e = exp_q.pop_front();
                            chk("cmd_op", 64'(cmd_op), 64'(e.op));
                            chk("cmd_addr", 64'(cmd_addr), 64'(e.addr));
                            if (e.op == OP_WRITE) chk("cmd_wdata", 64'(cmd_wdata), 64'(e.wdata));
                        end
                    end
                end else begin
                    chk("idle_fields_zero", 64'({cmd_op, cmd_addr, cmd_wdata}), 64'd0);
                end
            end
        end
    end

    // Responder: one-cycle completion pulse the cycle after acceptance
    initial begin
        rsp_valid = 1'b0;
        rsp_rdata = 8'h00;
        pend      = 1'b0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_rdata = 8'h00;
            if (pend && auto_rsp) begin
                rsp_valid = 1'b1;
                if (pend_cmd.op == OP_READ) begin
                    rsp_rdata    = corrupt_next ? 8'h5A : mem[pend_cmd.addr[7:0]];
                    corrupt_next = 1'b0;
                end else if (pend_cmd.op == OP_WRITE) begin
                    mem[pend_cmd.addr[7:0]] = pend_cmd.wdata;
                end
                pend = 1'b0;
            end
            if (rst_n && cmd_valid && cmd_ready) begin
                pend     = 1'b1;
                pend_cmd = '{cmd_op, cmd_addr, cmd_wdata};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        auto_rsp     = 1'b1;
        corrupt_next = 1'b0;
        rst_n        = 1'b0;
        key_short    = 1'b0;
        key_long     = 1'b0;
        cmd_ready    = 1'b1;
        m_addr       = c_BASE;
        m_data       = 8'h00;
        repeat (3) step();

        // Reset state
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_fields", 64'({cmd_op, cmd_addr, cmd_wdata}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_verify_err", 64'(verify_err), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        step();

        // Single short press with latency check
        exp_short();
        key_short = 1'b1;
        step();
        key_short = 1'b0;
        chk("lat_busy_after_push", 64'(busy), 64'd1);
        chk("lat_valid_edgeN", 64'(cmd_valid), 64'd0);
        step();
        chk("lat_valid_edgeN1", 64'(cmd_valid), 64'd0);
        step();
        chk("lat_valid_edgeN2", 64'(cmd_valid), 64'd1);
        chk("lat_op_write", 64'(cmd_op), 64'(OP_WRITE));
        wait_idle(100);
        chk("t1_verify_err", 64'(verify_err), 64'd0);

        // Read-back mismatch is sticky until erase
        corrupt_next = 1'b1;
        exp_short();
        pulse(1'b1, 1'b0, 1);
        wait_idle(100);
        chk("t2_verify_err_set", 64'(verify_err), 64'd1);
        exp_short();
        pulse(1'b1, 1'b0, 1);
        wait_idle(100);
        chk("t2_verify_err_sticky", 64'(verify_err), 64'd1);
        exp_long();
        pulse(1'b0, 1'b1, 1);
        wait_idle(100);
        chk("t2_verify_err_cleared", 64'(verify_err), 64'd0);
        exp_short();
        pulse(1'b1, 1'b0, 1);
        wait_idle(100);
        chk("t2_drop_cnt_zero", 64'(drop_cnt), 64'd0);

        // Queue overflow: one in WR_REQ, four queued, one dropped
        cmd_ready = 1'b0;
        repeat (5) exp_short();
        repeat (6) pulse(1'b1, 1'b0, 1);
        step();
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("ovf_cmd_valid", 64'(cmd_valid), 64'd1);
        chk("ovf_cmd_op", 64'(cmd_op), 64'(OP_WRITE));
        chk("ovf_busy", 64'(busy), 64'd1);
        cmd_ready = 1'b1;
        wait_idle(400);
        chk("ovf_drop_cnt_final", 64'(drop_cnt), 64'd1);

        // Coincident keys: erase only
        exp_long();
        pulse(1'b1, 1'b1, 1);
        wait_idle(100);
        // Held short key: one write/read pair
        exp_short();
        pulse(1'b1, 1'b0, 5);
        wait_idle(100);

        // Address wrap within a 4-byte span
        exp_long();
        pulse(1'b0, 1'b1, 1);
        wait_idle(100);
        repeat (5) begin
            exp_short();
            pulse(1'b1, 1'b0, 1);
            wait_idle(100);
        end
        chk("wrap_verify_err", 64'(verify_err), 64'd0);

        // Asynchronous reset while waiting for the write response
        auto_rsp = 1'b0;
        exp_q.push_back('{OP_WRITE, m_addr, m_data});
        pulse(1'b1, 1'b0, 1);
        for (int i = 0; i < 20 && !pend; i++) step();
        step();
        chk("mid_busy_before_rst", 64'(busy), 64'd1);
        chk("mid_valid_in_wait", 64'(cmd_valid), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("mid_rst_cmd", 64'({cmd_valid, cmd_op, cmd_addr, cmd_wdata}), 64'd0);
        step();
        rst_n    = 1'b1;
        auto_rsp = 1'b1;
        repeat (5) step();
        chk("stale_rsp_busy", 64'(busy), 64'd0);
        chk("stale_rsp_valid", 64'(cmd_valid), 64'd0);
        m_addr = c_BASE;
        m_data = 8'h00;
        exp_short();
        pulse(1'b1, 1'b0, 1);
        wait_idle(100);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
